// File: rtl/pred_ctx_pkg.sv
// Shared definitions for the predicate-path context sequencer: context word
// layout, NOP word and sequencer states.
package pred_ctx_pkg;

  localparam int unsigned CTX_W = 47;

  localparam int unsigned IN_LSB      = 0;
  localparam int unsigned IN_W        = 9;
  localparam int unsigned OUT_LSB     = 9;
  localparam int unsigned OUT_W       = 9;
  localparam int unsigned PUT_IN_LSB  = 18;
  localparam int unsigned PUT_IN_W    = 6;
  localparam int unsigned PUT_OUT_LSB = 24;
  localparam int unsigned PUT_OUT_W   = 6;
  localparam int unsigned PRED_LSB    = 30;
  localparam int unsigned PRED_W      = 6;
  localparam int unsigned SEND_LSB    = 36;
  localparam int unsigned SEND_W      = 6;
  localparam int unsigned PE2FU_LSB   = 42;
  localparam int unsigned PE2FU_W     = 4;
  localparam int unsigned WB_LSB      = 46;
  localparam int unsigned WB_W        = 1;

  // Entry 63 is a reserved scratch slot, so idle puts land there harmlessly.
  localparam logic [5:0] PRED_SCRATCH = 6'd63;

  localparam logic [CTX_W-1:0] NOP_WORD = {1'b0, 4'b1111, 6'd0, 6'd0,
                                           PRED_SCRATCH, PRED_SCRATCH,
                                           9'd0, 9'd0};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/pred_ctx_mem.sv
// Context word store: synchronous write, combinational read (read of an
// address written in the same cycle returns the old word).
module pred_ctx_mem
  import pred_ctx_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [CTX_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [CTX_W-1:0] rdata
);

  logic [CTX_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pred_ctx_seq.sv
// Predicate-path context sequencer: replays loaded context words for a
// programmed number of iterations, driving registered control fields.
module pred_ctx_seq
  import pred_ctx_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [CTX_W-1:0] cfg_data,
  input  logic [AW:0]      cfg_len,
  input  logic [7:0]       cfg_iter,
  input  logic             start,
  input  logic             stall,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic [AW-1:0]    ctx_ptr,
  output logic [8:0]       control_in_p,
  output logic [8:0]       control_out_p,
  output logic [5:0]       control_put_in_p,
  output logic [5:0]       control_put_out_p,
  output logic [5:0]       control_pred,
  output logic [5:0]       control_send_p,
  output logic [3:0]       control_pe2fu_p,
  output logic             write_back_p
);

  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0] LEN_ONE = (AW+1)'(1);

  state_t           state, state_n;
  logic [AW-1:0]    ptr, ptr_n;
  logic [7:0]       iter_cnt, iter_cnt_n, iter_q, iter_n;
  logic [AW:0]      len_q, len_n, len_clamped;
  logic [CTX_W-1:0] word_q, word_n, rdata;
  logic             busy_n, done_n, mem_we;

  pred_ctx_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (CLK),
    .we    (mem_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (ptr),
    .rdata (rdata)
  );

  assign len_clamped = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;

  // busy/done are registered alongside the outputs so they line up with the
  // issued words rather than with the internal state.
  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    iter_cnt_n = iter_cnt;
    len_n      = len_q;
    iter_n     = iter_q;
    word_n     = NOP_WORD;
    busy_n     = 1'b0;
    done_n     = 1'b0;
    mem_we     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        mem_we = cfg_we;
        if (start) begin
          if (cfg_len == '0 || cfg_iter == '0) begin
            state_n = ST_DONE;
          end else begin
            state_n    = ST_RUN;
            len_n      = len_clamped;
            iter_n     = cfg_iter;
            ptr_n      = '0;
            iter_cnt_n = '0;
          end
        end
      end
      ST_RUN: begin
        busy_n = 1'b1;
        if (!stall) begin
          word_n = rdata;
          if ({1'b0, ptr} == len_q - LEN_ONE) begin
            ptr_n      = '0;
            iter_cnt_n = iter_cnt + 8'd1;
            if (iter_cnt == iter_q - 8'd1) state_n = ST_DONE;
          end else begin
            ptr_n = ptr + AW'(1);
          end
        end
      end
      ST_DONE: begin
        mem_we  = cfg_we;
        done_n  = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr      <= '0;
      iter_cnt <= '0;
      iter_q   <= '0;
      len_q    <= '0;
      word_q   <= NOP_WORD;
      busy     <= 1'b0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      ptr      <= ptr_n;
      iter_cnt <= iter_cnt_n;
      iter_q   <= iter_n;
      len_q    <= len_n;
      word_q   <= word_n;
      busy     <= busy_n;
      done     <= done_n;
      cfg_err  <= cfg_we && (state == ST_RUN);
    end
  end

  assign ctx_ptr           = ptr;
  assign control_in_p      = word_q[IN_LSB      +: IN_W];
  assign control_out_p     = word_q[OUT_LSB     +: OUT_W];
  assign control_put_in_p  = word_q[PUT_IN_LSB  +: PUT_IN_W];
  assign control_put_out_p = word_q[PUT_OUT_LSB +: PUT_OUT_W];
  assign control_pred      = word_q[PRED_LSB    +: PRED_W];
  assign control_send_p    = word_q[SEND_LSB    +: SEND_W];
  assign control_pe2fu_p   = word_q[PE2FU_LSB   +: PE2FU_W];
  assign write_back_p      = word_q[WB_LSB      +: WB_W];

endmodule

// File: tb/tb_pred_ctx_seq.sv
// Scoreboard bench for pred_ctx_seq: expected per-cycle output words are
// queued from the timing rules and popped as the DUT produces them.
module tb_pred_ctx_seq;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam logic [46:0] TB_NOP = {1'b0, 4'hF, 6'd0, 6'd0, 6'd63, 6'd63, 9'd0, 9'd0};

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [46:0] cfg_data = '0;
  logic [AW:0] cfg_len = '0;
  logic [7:0]  cfg_iter = '0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        busy, done, cfg_err;
  logic [AW-1:0] ctx_ptr;
  logic [8:0]  control_in_p, control_out_p;
  logic [5:0]  control_put_in_p, control_put_out_p, control_pred, control_send_p;
  logic [3:0]  control_pe2fu_p;
  logic        write_back_p;
  logic [46:0] obs;

  typedef struct {
    logic [46:0] word;
    logic        busy;
    logic        done;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [46:0] tb_mem [DEPTH];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  pred_ctx_seq #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK (clk), .RST (RST),
    .cfg_we (cfg_we), .cfg_addr (cfg_addr), .cfg_data (cfg_data),
    .cfg_len (cfg_len), .cfg_iter (cfg_iter), .start (start), .stall (stall),
    .busy (busy), .done (done), .cfg_err (cfg_err), .ctx_ptr (ctx_ptr),
    .control_in_p (control_in_p), .control_out_p (control_out_p),
    .control_put_in_p (control_put_in_p), .control_put_out_p (control_put_out_p),
    .control_pred (control_pred), .control_send_p (control_send_p),
    .control_pe2fu_p (control_pe2fu_p), .write_back_p (write_back_p)
  );

  assign obs = {write_back_p, control_pe2fu_p, control_send_p, control_pred,
                control_put_out_p, control_put_in_p, control_out_p, control_in_p};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_ctx(input int addr, input logic [46:0] data);
    cfg_we   = 1'b1;
    cfg_addr = addr[AW-1:0];
    cfg_data = data;
    tick();
    cfg_we = 1'b0;
    tb_mem[addr] = data;
  endtask

  // stall_e / wr_e / rst_e name the edge (relative to the start edge) at
  // which that input is sampled; 0 disables it.
  task automatic run_prog(input string tag, input int len, input int iter,
                          input int stall_e, input int wr_e, input int rst_e);
    int   leff, total, c, j;
    bit   cut;
    exp_t e;
    leff  = (len > int'(DEPTH)) ? int'(DEPTH) : len;
    total = (len == 0 || iter == 0) ? 0 : leff * iter;
    exp_q.delete();
    exp_q.push_back('{TB_NOP, 1'b0, 1'b0, 1'b0});
    c = 1; j = 0; cut = 0;
    while (j < total) begin
      if (c == rst_e) begin
        cut = 1;
        break;
      end
      if (c == stall_e) e = '{TB_NOP, 1'b1, 1'b0, 1'b0};
      else begin
        e = '{tb_mem[j % leff], 1'b1, 1'b0, 1'b0};
        j++;
      end
      e.err = (c == wr_e);
      exp_q.push_back(e);
      c++;
    end
    if (cut) begin
      exp_q.push_back('{TB_NOP, 1'b0, 1'b0, 1'b0});
      exp_q.push_back('{TB_NOP, 1'b0, 1'b0, 1'b0});
    end else begin
      exp_q.push_back('{TB_NOP, 1'b0, 1'b1, 1'b0});
      exp_q.push_back('{TB_NOP, 1'b0, 1'b0, 1'b0});
    end

    cfg_len  = len[AW:0];
    cfg_iter = iter[7:0];
    start    = 1'b1;
    tick();
    start = 1'b0;
    c = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (obs !== e.word) begin
        n_fail++;
        $display("FAIL %s word c%0d: got %h exp %h", tag, c, obs, e.word);
      end
      n_tests++;
      if (busy !== e.busy) begin
        n_fail++;
        $display("FAIL %s busy c%0d: got %b exp %b", tag, c, busy, e.busy);
      end
      n_tests++;
      if (done !== e.done) begin
        n_fail++;
        $display("FAIL %s done c%0d: got %b exp %b", tag, c, done, e.done);
      end
      n_tests++;
      if (cfg_err !== e.err) begin
        n_fail++;
        $display("FAIL %s cfg_err c%0d: got %b exp %b", tag, c, cfg_err, e.err);
      end
      c++;
      stall = (c == stall_e);
      RST   = (c == rst_e);
      if (c == wr_e) begin
        cfg_we   = 1'b1;
        cfg_addr = AW'(1);
        cfg_data = ~tb_mem[1];
      end else begin
        cfg_we = 1'b0;
      end
      if (exp_q.size() > 0) tick();
    end
    stall  = 1'b0;
    RST    = 1'b0;
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    n_tests++;
    if (obs !== TB_NOP) begin
      n_fail++;
      $display("FAIL reset_word: got %h exp %h", obs, TB_NOP);
    end
    n_tests++;
    if (control_put_in_p !== 6'd63 || control_pe2fu_p !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_fields: got put_in=%0d pe2fu=%h exp 63 f", control_put_in_p, control_pe2fu_p);
    end
    n_tests++;
    if ({busy, done, cfg_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b exp 000", {busy, done, cfg_err});
    end
    n_tests++;
    if (ctx_ptr !== '0) begin
      n_fail++;
      $display("FAIL reset_ptr: got %0d exp 0", ctx_ptr);
    end
  endtask

  task automatic test_load();
    for (int i = 0; i < int'(DEPTH); i++)
      write_ctx(i, {$urandom, $urandom} & {47{1'b1}});
  endtask

  task automatic test_basic();
    run_prog("basic", 3, 2, 0, 0, 0);
  endtask

  task automatic test_stall();
    run_prog("stall", 3, 2, 2, 0, 0);
  endtask

  task automatic test_zero();
    run_prog("zero_iter", 3, 0, 0, 0, 0);
    run_prog("zero_len", 0, 2, 0, 0, 0);
  endtask

  task automatic test_cfg_during_run();
    logic [46:0] fresh;
    run_prog("cfg_in_run", 3, 2, 0, 2, 0);
    fresh = ~tb_mem[1] ^ 47'h1234_5678;
    write_ctx(1, fresh);
    run_prog("cfg_idle", 3, 1, 0, 0, 0);
  endtask

  task automatic test_reset_mid_run();
    run_prog("rst_mid", 3, 2, 0, 0, 5);
    run_prog("rst_replay", 3, 2, 0, 0, 0);
  endtask

  task automatic test_clamp();
    run_prog("clamp", 20, 1, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    run_prog("b2b_a", 2, 3, 0, 0, 0);
    run_prog("b2b_b", 5, 1, 3, 0, 0);
  endtask

  initial begin
    test_reset();
    test_load();
    test_basic();
    test_stall();
    test_zero();
    test_cfg_during_run();
    test_reset_mid_run();
    test_clamp();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
